// File: rtl/envase_linha_param.sv
// Parametrised bottling-line controller: one FSM sequences conveyor, fill and inspection,
// and also keeps the cork stock, the box fill count and the completed-box tally.
// Latency: Moore outputs, registered, updating on the edge that enters a state. Backpressure: INSPECT waits indefinitely for a verdict.
// Optional build macro REJECT_COUNT_EN enables a saturating reject counter; when it is undefined, rejeitadas is tied to 0.
module envase_linha_param #(
    parameter int CORK_MAX     = 31,
    parameter int BOX_SIZE     = 12,
    parameter int BOXES_W      = 8,
    parameter int FILL_TIMEOUT = 16,
    parameter int REJ_W        = 8,
    localparam int CORK_W      = $clog2(CORK_MAX + 1),
    localparam int BOX_W       = $clog2(BOX_SIZE),
    localparam int TMR_W       = $clog2(FILL_TIMEOUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               garrafa,
    input  logic               sensor_nivel,
    input  logic               aprovada,
    input  logic               reprovada,
    input  logic               incrementar,
    output logic               motor,
    output logic               valvula,
    output logic               led_erro,
    output logic               led_descarte,
    output logic [CORK_W-1:0]  num_rolhas,
    output logic [BOX_W-1:0]   garrafas_caixa,
    output logic [BOXES_W-1:0] caixas,
    output logic               caixa_cheia,
    output logic [REJ_W-1:0]   rejeitadas
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MOVE    = 3'd1,
        S_FILL    = 3'd2,
        S_CORK    = 3'd3,
        S_INSPECT = 3'd4,
        S_DISCARD = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    localparam logic [CORK_W-1:0] CORK_FULL = CORK_W'(CORK_MAX);
    localparam logic [BOX_W-1:0]  BOX_LAST  = BOX_W'(BOX_SIZE - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(FILL_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [CORK_W-1:0]   rolhas_q, rolhas_d;
    logic [BOX_W-1:0]    garrafas_q;
    logic [BOXES_W-1:0]  caixas_q;
    logic                motor_q, valvula_q, led_erro_q, led_descarte_q, caixa_cheia_q;

    logic                cork_dec;
    logic                approve;
    logic                box_wrap;
    logic                stock_ok;
    state_t              exit_state;

    // Corking consumes a cork only when stock is available; an approval is a pass without a fail.
    assign cork_dec = (state_q == S_CORK) && (rolhas_q != '0);
    assign approve  = (state_q == S_INSPECT) && aprovada && !reprovada;
    assign box_wrap = approve && (garrafas_q == BOX_LAST);
    assign stock_ok = (rolhas_q != '0);

    // Cork stock next value: saturating refill, and a same-cycle refill cancels the corking decrement.
    always_comb begin
        rolhas_d = rolhas_q;
        if (cork_dec) begin
            if (!incrementar) begin
                rolhas_d = rolhas_q - CORK_W'(1);
            end
        end else if (incrementar && (rolhas_q != CORK_FULL)) begin
            rolhas_d = rolhas_q + CORK_W'(1);
        end
    end

    // Leaving INSPECT/DISCARD looks at the stock as it will be after this cycle's refill.
    always_comb begin
        if (!start) begin
            exit_state = S_IDLE;
        end else if (rolhas_d != '0) begin
            exit_state = S_MOVE;
        end else begin
            exit_state = S_ERROR;
        end
    end

    // Next-state logic and fill-timer control.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = stock_ok ? S_MOVE : S_ERROR;
                end
            end
            S_MOVE: begin
                if (garrafa) begin
                    state_d = S_FILL;
                    tmr_d   = '0;
                end
            end
            S_FILL: begin
                // The level sensor wins over a timeout landing on the same cycle.
                if (sensor_nivel) begin
                    state_d = S_CORK;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_CORK: begin
                state_d = stock_ok ? S_INSPECT : S_ERROR;
            end
            S_INSPECT: begin
                if (reprovada) begin
                    state_d = S_DISCARD;
                end else if (aprovada) begin
                    state_d = exit_state;
                end
            end
            S_DISCARD: begin
                state_d = exit_state;
            end
            S_ERROR: begin
                if (!start && stock_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            tmr_q          <= '0;
            motor_q        <= 1'b0;
            valvula_q      <= 1'b0;
            led_erro_q     <= 1'b0;
            led_descarte_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            motor_q        <= (state_d == S_MOVE);
            valvula_q      <= (state_d == S_FILL);
            led_erro_q     <= (state_d == S_ERROR);
            led_descarte_q <= (state_d == S_DISCARD);
        end
    end

    // Cork stock, box fill count, completed-box tally and the box-complete pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rolhas_q      <= '0;
            garrafas_q    <= '0;
            caixas_q      <= '0;
            caixa_cheia_q <= 1'b0;
        end else begin
            rolhas_q      <= rolhas_d;
            caixa_cheia_q <= box_wrap;
            if (box_wrap) begin
                garrafas_q <= '0;
                caixas_q   <= caixas_q + BOXES_W'(1);
            end else if (approve) begin
                garrafas_q <= garrafas_q + BOX_W'(1);
            end
        end
    end

`ifdef REJECT_COUNT_EN
    logic [REJ_W-1:0] rej_q;

    // Reject tally bumps on each DISCARD entry and sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rej_q <= '0;
        end else if ((state_q == S_INSPECT) && reprovada && !(&rej_q)) begin
            rej_q <= rej_q + REJ_W'(1);
        end
    end

    assign rejeitadas = rej_q;
`else
    assign rejeitadas = '0;
`endif

    assign motor          = motor_q;
    assign valvula        = valvula_q;
    assign led_erro       = led_erro_q;
    assign led_descarte   = led_descarte_q;
    assign num_rolhas     = rolhas_q;
    assign garrafas_caixa = garrafas_q;
    assign caixas         = caixas_q;
    assign caixa_cheia    = caixa_cheia_q;

endmodule

// File: tb/tb_envase_linha_param.sv
// Directed bench for envase_linha_param with default parameters.
// Inputs change 1 ns after the rising edge, and outputs are sampled at that same point.
// Each scenario task checks its own expected values inline.
module tb_envase_linha_param;

    logic       clk;
    logic       reset;
    logic       start, garrafa, sensor_nivel, aprovada, reprovada, incrementar;
    logic       motor, valvula, led_erro, led_descarte, caixa_cheia;
    logic [5:0] num_rolhas;
    logic [3:0] garrafas_caixa;
    logic [7:0] caixas;
    logic [7:0] rejeitadas;

    int checks = 0;
    int errors = 0;

    envase_linha_param dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .garrafa        (garrafa),
        .sensor_nivel   (sensor_nivel),
        .aprovada       (aprovada),
        .reprovada      (reprovada),
        .incrementar    (incrementar),
        .motor          (motor),
        .valvula        (valvula),
        .led_erro       (led_erro),
        .led_descarte   (led_descarte),
        .num_rolhas     (num_rolhas),
        .garrafas_caixa (garrafas_caixa),
        .caixas         (caixas),
        .caixa_cheia    (caixa_cheia),
        .rejeitadas     (rejeitadas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; garrafa = 0; sensor_nivel = 0;
        aprovada = 0; reprovada = 0; incrementar = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // Runs one bottle from IDLE back to IDLE; start drops once the bottle is in CORK.
    task automatic run_bottle(input logic rej, input logic inc_cork,
                              output logic pulse, output logic desc);
        start = 1; garrafa = 1; sensor_nivel = 1; aprovada = 1; reprovada = rej;
        tick();                 // MOVE
        tick();                 // FILL
        tick();                 // CORK
        start = 0;
        incrementar = inc_cork;
        tick();                 // INSPECT
        incrementar = 0;
        tick();                 // IDLE or DISCARD
        pulse = caixa_cheia;
        desc  = led_descarte;
        if (rej) tick();        // DISCARD -> IDLE
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        #2;
        checks++;
        if ({motor, valvula, led_erro, led_descarte, caixa_cheia} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {motor, valvula, led_erro, led_descarte, caixa_cheia});
        end
        checks++;
        if (num_rolhas !== 6'd0 || garrafas_caixa !== 4'd0 || caixas !== 8'd0 || rejeitadas !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters got %0d/%0d/%0d/%0d want 0/0/0/0", num_rolhas, garrafas_caixa, caixas, rejeitadas);
        end
        tick();
        reset = 0;
    endtask

    task automatic test_basic_cycle();
        incrementar = 1;
        repeat (3) tick();
        incrementar = 0;
        checks++;
        if (num_rolhas !== 6'd3) begin errors++; $display("FAIL basic_stock got %0d want 3", num_rolhas); end
        start = 1; garrafa = 1; sensor_nivel = 1; aprovada = 1;
        tick();
        checks++;
        if ({motor, valvula} !== 2'b10) begin errors++; $display("FAIL basic_move got %b want 10", {motor, valvula}); end
        tick();
        checks++;
        if ({motor, valvula} !== 2'b01) begin errors++; $display("FAIL basic_fill got %b want 01", {motor, valvula}); end
        tick();
        checks++;
        if ({motor, valvula} !== 2'b00 || num_rolhas !== 6'd3) begin
            errors++; $display("FAIL basic_cork got %b stock %0d want 00 stock 3", {motor, valvula}, num_rolhas);
        end
        start = 0;
        tick();
        checks++;
        if (num_rolhas !== 6'd2) begin errors++; $display("FAIL basic_decrement got %0d want 2", num_rolhas); end
        tick();
        checks++;
        if (garrafas_caixa !== 4'd1 || motor !== 1'b0) begin
            errors++; $display("FAIL basic_approve got count %0d motor %b want 1 0", garrafas_caixa, motor);
        end
        clear_inputs();
    endtask

    task automatic test_no_stock();
        do_reset();
        start = 1;
        tick();
        checks++;
        if (led_erro !== 1'b1 || motor !== 1'b0) begin
            errors++; $display("FAIL nostock_error got led %b motor %b want 1 0", led_erro, motor);
        end
        start = 0; incrementar = 1;
        tick();
        incrementar = 0;
        checks++;
        if (led_erro !== 1'b1 || num_rolhas !== 6'd1) begin
            errors++; $display("FAIL nostock_refill got led %b stock %0d want 1 1", led_erro, num_rolhas);
        end
        tick();
        checks++;
        if (led_erro !== 1'b0) begin errors++; $display("FAIL nostock_recover got %b want 0", led_erro); end
    endtask

    task automatic test_fill_timeout();
        int bad;
        bad = 0;
        start = 1; garrafa = 1; sensor_nivel = 0;
        tick();
        tick();
        checks++;
        if (valvula !== 1'b1) begin errors++; $display("FAIL timeout_enter got %b want 1", valvula); end
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (valvula !== 1'b1 || led_erro !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL timeout_hold got %0d bad cycles want 0", bad); end
        tick();
        checks++;
        if ({valvula, led_erro} !== 2'b01) begin
            errors++; $display("FAIL timeout_fault got %b want 01", {valvula, led_erro});
        end
        start = 0; garrafa = 0;
        tick();
        checks++;
        if (led_erro !== 1'b0) begin errors++; $display("FAIL timeout_recover got %b want 0", led_erro); end
    endtask

    task automatic test_box_wrap();
        logic p, d;
        int pulses;
        pulses = 0;
        do_reset();
        incrementar = 1;
        repeat (15) tick();
        incrementar = 0;
        for (int b = 0; b < 11; b++) begin
            run_bottle(1'b0, 1'b0, p, d);
            if (p === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || garrafas_caixa !== 4'd11 || caixas !== 8'd0) begin
            errors++; $display("FAIL box_partial got pulses %0d count %0d boxes %0d want 0 11 0", pulses, garrafas_caixa, caixas);
        end
        run_bottle(1'b0, 1'b0, p, d);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL box_pulse got %b want 1", p); end
        checks++;
        if (garrafas_caixa !== 4'd0 || caixas !== 8'd1 || num_rolhas !== 6'd3) begin
            errors++; $display("FAIL box_wrap got count %0d boxes %0d stock %0d want 0 1 3", garrafas_caixa, caixas, num_rolhas);
        end
        tick();
        checks++;
        if (caixa_cheia !== 1'b0) begin errors++; $display("FAIL box_pulse_end got %b want 0", caixa_cheia); end
    endtask

    task automatic test_discard();
        logic p, d;
        logic [7:0] rej_exp;
`ifdef REJECT_COUNT_EN
        rej_exp = 8'd1;
`else
        rej_exp = 8'd0;
`endif
        run_bottle(1'b1, 1'b0, p, d);
        checks++;
        if (d !== 1'b1 || p !== 1'b0) begin
            errors++; $display("FAIL discard_pulse got desc %b box %b want 1 0", d, p);
        end
        checks++;
        if (led_descarte !== 1'b0) begin errors++; $display("FAIL discard_end got %b want 0", led_descarte); end
        checks++;
        if (garrafas_caixa !== 4'd0 || caixas !== 8'd1 || num_rolhas !== 6'd2) begin
            errors++; $display("FAIL discard_counts got %0d %0d %0d want 0 1 2", garrafas_caixa, caixas, num_rolhas);
        end
        checks++;
        if (rejeitadas !== rej_exp) begin errors++; $display("FAIL discard_rejects got %0d want %0d", rejeitadas, rej_exp); end
    endtask

    task automatic test_cork_saturation();
        logic p, d;
        incrementar = 1;
        repeat (40) tick();
        checks++;
        if (num_rolhas !== 6'd31) begin errors++; $display("FAIL sat_fill got %0d want 31", num_rolhas); end
        repeat (4) tick();
        incrementar = 0;
        checks++;
        if (num_rolhas !== 6'd31) begin errors++; $display("FAIL sat_hold got %0d want 31", num_rolhas); end
        run_bottle(1'b0, 1'b1, p, d);
        checks++;
        if (num_rolhas !== 6'd31) begin errors++; $display("FAIL sat_cork_inc_full got %0d want 31", num_rolhas); end
        run_bottle(1'b0, 1'b0, p, d);
        checks++;
        if (num_rolhas !== 6'd30) begin errors++; $display("FAIL sat_cork_plain got %0d want 30", num_rolhas); end
        run_bottle(1'b0, 1'b1, p, d);
        checks++;
        if (num_rolhas !== 6'd30) begin errors++; $display("FAIL sat_cork_inc got %0d want 30", num_rolhas); end
    endtask

    task automatic test_reset_midop();
        start = 1; garrafa = 1; sensor_nivel = 0;
        tick();
        tick();
        checks++;
        if (valvula !== 1'b1) begin errors++; $display("FAIL midop_fill got %b want 1", valvula); end
        reset = 1;
        #2;
        checks++;
        if (valvula !== 1'b0 || num_rolhas !== 6'd0 || caixas !== 8'd0 || caixa_cheia !== 1'b0) begin
            errors++; $display("FAIL midop_reset got valve %b stock %0d boxes %0d pulse %b want 0 0 0 0",
                                valvula, num_rolhas, caixas, caixa_cheia);
        end
        clear_inputs();
        tick();
        reset = 0;
        tick();
        checks++;
        if ({motor, valvula, led_erro} !== 3'b000) begin
            errors++; $display("FAIL midop_idle got %b want 000", {motor, valvula, led_erro});
        end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_basic_cycle();
        test_no_stock();
        test_fill_timeout();
        test_box_wrap();
        test_discard();
        test_cork_saturation();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
